am_env_detector: RTL and testbench

- AM envelope demodulator between the AD9226 capture stage (12-bit offset-binary samples) and the AD9764 output mapping stage.
- Rectifies each sample and boxcar-averages over 2^LOG2_DECIM samples to form a decimated envelope.
- Tracks the envelope DC level with a leaky integrator and outputs both the DC level and the AC (audio) component.
- Samples arrive as a strobe-qualified stream in the system clock domain.

---
 rtl/am_dsp_pkg.sv | 20 ++
 rtl/am_boxcar_decim.sv | 46 ++++
 rtl/am_env_detector.sv | 81 ++++++++
 tb/tb_am_env_detector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/am_dsp_pkg.sv
// Shared ADC constants and the offset-binary to rectified-magnitude helper.
// Pure package: no latency, no flow control.
package am_dsp_pkg;

  localparam int ADC_W   = 12;
  localparam int ADC_MID = 2048;

  // Invert the MSB to get two's complement, then take |s|; -2048 clips to 2047.
  function automatic logic [ADC_W-1:0] ob_to_mag(input logic [ADC_W-1:0] ob);
    logic [ADC_W-1:0] s;
    s = {~ob[ADC_W-1], ob[ADC_W-2:0]};
    if (!s[ADC_W-1])
      return s;
    else if (s == {1'b1, {(ADC_W-1){1'b0}}})
      return {1'b0, {(ADC_W-1){1'b1}}};
    else
      return ~s + 1'b1;
  endfunction

endpackage

// File: rtl/am_boxcar_decim.sv
// Boxcar average of 2^LOG2_DECIM rectified samples; env registered, env_v pulses
// one cycle after the block's last rect_v. No backpressure: accepts a sample every cycle.
module am_boxcar_decim
  import am_dsp_pkg::*;
#(
  parameter int LOG2_DECIM = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] rect,
  input  logic             rect_v,
  output logic [ADC_W-1:0] env,
  output logic             env_v
);

  localparam int ACC_W = ADC_W + LOG2_DECIM;

  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      sum;
  logic [LOG2_DECIM-1:0] cnt;

  assign sum = acc + ACC_W'(rect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      env   <= '0;
      env_v <= 1'b0;
    end else begin
      env_v <= 1'b0;
      if (rect_v) begin
        // All-ones count marks the last sample of the block; cnt wraps naturally.
        if (cnt == '1) begin
          env   <= ADC_W'(sum >> LOG2_DECIM);
          env_v <= 1'b1;
          acc   <= '0;
        end else begin
          acc <= sum;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/am_env_detector.sv
// AM envelope detector: rectify, boxcar-decimate, split into DC and AC via leaky integrator.
// Latency 3 cycles from the last sample of a block to dout_valid; no backpressure.
module am_env_detector
  import am_dsp_pkg::*;
#(
  parameter int LOG2_DECIM = 4,
  parameter int DC_SHIFT   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] data_in,
  input  logic             din_valid,
  output logic [ADC_W-1:0] env_dc,
  output logic [ADC_W-1:0] env_ac,
  output logic             dout_valid
);

  localparam int DC_W = ADC_W + DC_SHIFT;

  logic [ADC_W-1:0] rect;
  logic             rect_v;
  logic [ADC_W-1:0] env;
  logic             env_v;
  logic [DC_W-1:0]  dc_acc;
  logic [DC_W-1:0]  dc_next;
  logic [ADC_W-1:0] dc_old;
  logic             seeded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rect   <= '0;
      rect_v <= 1'b0;
    end else begin
      rect_v <= din_valid;
      if (din_valid) rect <= ob_to_mag(data_in);
    end
  end

  am_boxcar_decim #(
    .LOG2_DECIM(LOG2_DECIM)
  ) u_boxcar (
    .clk   (clk),
    .rst_n (rst_n),
    .rect  (rect),
    .rect_v(rect_v),
    .env   (env),
    .env_v (env_v)
  );

  always_comb begin
    dc_old  = ADC_W'(dc_acc >> DC_SHIFT);
    dc_next = dc_acc + DC_W'(env) - DC_W'(dc_old);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_acc     <= '0;
      seeded     <= 1'b0;
      env_dc     <= '0;
      env_ac     <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (env_v) begin
        dout_valid <= 1'b1;
        // First envelope seeds the integrator so DC starts settled instead of ramping from 0.
        if (!seeded) begin
          dc_acc <= {env, {DC_SHIFT{1'b0}}};
          env_dc <= env;
          env_ac <= '0;
          seeded <= 1'b1;
        end else begin
          dc_acc <= dc_next;
          env_dc <= ADC_W'(dc_next >> DC_SHIFT);
          env_ac <= env - dc_old;
        end
      end
    end
  end

endmodule

// File: tb/tb_am_env_detector.sv
// Scoreboard bench for am_env_detector: a block-averaging reference model queues expected
// outputs with their due cycle; a negedge monitor pops and compares on every dout_valid.
module tb_am_env_detector;
  import am_dsp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] data_in = '0;
  logic        din_valid = 1'b0;
  logic [11:0] env_dc;
  logic [11:0] env_ac;
  logic        dout_valid;

  am_env_detector #(.LOG2_DECIM(4), .DC_SHIFT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .din_valid (din_valid),
    .env_dc    (env_dc),
    .env_ac    (env_ac),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int c;
    int dc;
    int ac;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  int blk_sum, blk_n, dc_acc;
  bit seeded;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    blk_sum = 0;
    blk_n   = 0;
    seeded  = 1'b0;
    dc_acc  = 0;
  endtask

  // Reference: mean of |sample-2048| over 16 samples, then integer leaky integrator.
  task automatic model_sample(input int d, input int due);
    int r, env;
    exp_t e;
    r = d - ADC_MID;
    if (r < 0) r = -r;
    if (r > 2047) r = 2047;
    blk_sum += r;
    blk_n++;
    if (blk_n == 16) begin
      env = blk_sum / 16;
      blk_sum = 0;
      blk_n = 0;
      e.c = due;
      if (!seeded) begin
        seeded = 1'b1;
        dc_acc = env * 256;
        e.dc = env;
        e.ac = 0;
      end else begin
        e.ac = env - dc_acc / 256;
        dc_acc = dc_acc + env - dc_acc / 256;
        e.dc = dc_acc / 256;
      end
      sbq.push_back(e);
    end
  endtask

  task automatic send(input int d, input int gap);
    @(posedge clk);
    #1;
    data_in   = 12'(d);
    din_valid = 1'b1;
    model_sample(d, cyc + 3);
    repeat (gap) begin
      @(posedge clk);
      #1 din_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 din_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    check("rst_env_dc", env_dc, 0);
    check("rst_env_ac", $signed(env_ac), 0);
    check("rst_dout_valid", dout_valid, 0);
    model_reset();
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("pulse_cycle", cyc, e.c);
          check("env_dc", env_dc, e.dc);
          check("env_ac", $signed(env_ac), e.ac);
          check("env_dc_range", int'(env_dc <= 12'd2047), 1);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].c) begin
        check("missed_pulse", cyc, sbq[0].c);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("init_env_dc", env_dc, 0);
    check("init_env_ac", $signed(env_ac), 0);
    check("init_dout_valid", dout_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 48; i++) send(3048, 0);
    idle(6);
    do_reset();
    for (int i = 0; i < 48; i++) send(1048, 0);
    idle(6);
    do_reset();
    for (int i = 0; i < 32; i++) send(0, 0);
    idle(6);
    do_reset();
    for (int i = 0; i < 32; i++) send(2048, 0);
    idle(6);
    do_reset();
    for (int i = 0; i < 16; i++) send(3048, 0);
    for (int i = 0; i < 32; i++) send(3548, 0);
    idle(6);
    do_reset();
    for (int i = 0; i < 48; i++) send(3048, 3);
    idle(6);
    // Mid-block reset while outputs hold a nonzero envelope.
    for (int i = 0; i < 10; i++) send(3548, 0);
    do_reset();
    for (int i = 0; i < 16; i++) send(3048, 0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 16; i++) send((b % 2 == 0) ? 2548 : 3548, 0);
    idle(6);
    for (int i = 0; i < 192; i++) send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 2)));
    idle(10);
    check("drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
